// File: rtl/pipe_controller.sv
// RV32I pipelined control unit: decodes the ID instruction and carries the
// control bundle through the ID/EX, EX/MEM and MEM/WB registers.
module pipe_controller #(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned IMM_SRC_W  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [6:0]            op_d_i,
  input  logic [2:0]            funct3_d_i,
  input  logic                  funct7b5_d_i,
  input  logic                  flush_e_i,
  input  logic                  stall_e_i,
  input  logic                  zero_e_i,
  input  logic                  lt_e_i,
  input  logic                  ltu_e_i,
  output logic [IMM_SRC_W-1:0]  imm_src_d_o,
  output logic                  illegal_d_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e_o,
  output logic                  alu_src_e_o,
  output logic                  alu_a_pc_e_o,
  output logic                  jalr_e_o,
  output logic                  pc_src_e_o,
  output logic [1:0]            result_src_e_o,
  output logic                  reg_write_m_o,
  output logic                  mem_write_m_o,
  output logic [2:0]            funct3_m_o,
  output logic [1:0]            result_src_w_o,
  output logic                  reg_write_w_o
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic alu_op_t alu_from_funct(input logic       is_r,
                                             input logic [2:0] f3,
                                             input logic       f7b5);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic       w_reg_write_d, w_mem_write_d, w_branch_d, w_jump_d, w_jalr_d;
  logic       w_alu_src_d, w_alu_a_pc_d, w_illegal_d;
  logic [1:0] w_result_src_d;
  logic [2:0] w_funct3_d;
  alu_op_t    w_alu_d;
  imm_sel_t   w_imm_d;

  always_comb begin
    w_reg_write_d  = 1'b0;
    w_mem_write_d  = 1'b0;
    w_branch_d     = 1'b0;
    w_jump_d       = 1'b0;
    w_jalr_d       = 1'b0;
    w_alu_src_d    = 1'b0;
    w_alu_a_pc_d   = 1'b0;
    w_illegal_d    = 1'b0;
    w_result_src_d = 2'd0;
    w_alu_d        = ALU_ADD;
    w_imm_d        = IMM_I;
    case (op_d_i)
      OP_R: begin
        w_reg_write_d = 1'b1;
        w_alu_d       = alu_from_funct(1'b1, funct3_d_i, funct7b5_d_i);
      end
      OP_I: begin
        w_reg_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
        w_alu_d       = alu_from_funct(1'b0, funct3_d_i, funct7b5_d_i);
      end
      OP_LOAD: begin
        w_reg_write_d  = 1'b1;
        w_alu_src_d    = 1'b1;
        w_result_src_d = 2'd1;
      end
      OP_STORE: begin
        w_mem_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
        w_imm_d       = IMM_S;
      end
      OP_BRANCH: begin
        w_branch_d = 1'b1;
        w_imm_d    = IMM_B;
        w_alu_d    = ALU_SUB;
      end
      OP_JAL: begin
        w_jump_d       = 1'b1;
        w_reg_write_d  = 1'b1;
        w_result_src_d = 2'd2;
        w_imm_d        = IMM_J;
      end
      OP_JALR: begin
        w_jump_d       = 1'b1;
        w_jalr_d       = 1'b1;
        w_reg_write_d  = 1'b1;
        w_result_src_d = 2'd2;
        w_alu_src_d    = 1'b1;
      end
      OP_LUI: begin
        w_alu_src_d = 1'b1;
        w_imm_d     = IMM_U;
        w_alu_d     = ALU_PASSB;
      end
      OP_AUIPC: begin
        w_alu_src_d  = 1'b1;
        w_alu_a_pc_d = 1'b1;
        w_imm_d      = IMM_U;
      end
      default: w_illegal_d = 1'b1;
    endcase
  end

  // An illegal instruction must enter EX as a full bubble, funct3 included.
  assign w_funct3_d = w_illegal_d ? '0 : funct3_d_i;

  logic       r_reg_write_e, r_mem_write_e, r_branch_e, r_jump_e, r_jalr_e;
  logic       r_alu_src_e, r_alu_a_pc_e;
  logic [1:0] r_result_src_e;
  logic [2:0] r_funct3_e;
  alu_op_t    r_alu_e;
  logic       r_reg_write_m, r_mem_write_m;
  logic [1:0] r_result_src_m;
  logic [2:0] r_funct3_m;
  logic       r_reg_write_w;
  logic [1:0] r_result_src_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reg_write_e  <= 1'b0;
      r_mem_write_e  <= 1'b0;
      r_branch_e     <= 1'b0;
      r_jump_e       <= 1'b0;
      r_jalr_e       <= 1'b0;
      r_alu_src_e    <= 1'b0;
      r_alu_a_pc_e   <= 1'b0;
      r_result_src_e <= '0;
      r_funct3_e     <= '0;
      r_alu_e        <= ALU_ADD;
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= '0;
      r_funct3_m     <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= '0;
    end else if (!stall_e_i) begin
      if (flush_e_i) begin
        r_reg_write_e  <= 1'b0;
        r_mem_write_e  <= 1'b0;
        r_branch_e     <= 1'b0;
        r_jump_e       <= 1'b0;
        r_jalr_e       <= 1'b0;
        r_alu_src_e    <= 1'b0;
        r_alu_a_pc_e   <= 1'b0;
        r_result_src_e <= '0;
        r_funct3_e     <= '0;
        r_alu_e        <= ALU_ADD;
      end else begin
        r_reg_write_e  <= w_reg_write_d;
        r_mem_write_e  <= w_mem_write_d;
        r_branch_e     <= w_branch_d;
        r_jump_e       <= w_jump_d;
        r_jalr_e       <= w_jalr_d;
        r_alu_src_e    <= w_alu_src_d;
        r_alu_a_pc_e   <= w_alu_a_pc_d;
        r_result_src_e <= w_result_src_d;
        r_funct3_e     <= w_funct3_d;
        r_alu_e        <= w_alu_d;
      end
      r_reg_write_m  <= r_reg_write_e;
      r_mem_write_m  <= r_mem_write_e;
      r_result_src_m <= r_result_src_e;
      r_funct3_m     <= r_funct3_e;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
    end
  end

  logic w_cond_e;

  always_comb begin
    w_cond_e = 1'b0;
    case (r_funct3_e)
      3'b000:  w_cond_e = zero_e_i;
      3'b001:  w_cond_e = ~zero_e_i;
      3'b100:  w_cond_e = lt_e_i;
      3'b101:  w_cond_e = ~lt_e_i;
      3'b110:  w_cond_e = ltu_e_i;
      3'b111:  w_cond_e = ~ltu_e_i;
      default: w_cond_e = 1'b0;
    endcase
  end

  assign imm_src_d_o    = IMM_SRC_W'(w_imm_d);
  assign illegal_d_o    = w_illegal_d;
  assign alu_ctrl_e_o   = ALU_CTRL_W'(r_alu_e);
  assign alu_src_e_o    = r_alu_src_e;
  assign alu_a_pc_e_o   = r_alu_a_pc_e;
  assign jalr_e_o       = r_jalr_e;
  assign pc_src_e_o     = r_jump_e | (r_branch_e & w_cond_e);
  assign result_src_e_o = r_result_src_e;
  assign reg_write_m_o  = r_reg_write_m;
  assign mem_write_m_o  = r_mem_write_m;
  assign funct3_m_o     = r_funct3_m;
  assign result_src_w_o = r_result_src_w;
  assign reg_write_w_o  = r_reg_write_w;

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
Pipelined RV32I control unit. Decodes opcode/funct fields in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. Resolves all six branch conditions in EX from datapath flags and supports flush and stall of the ID/EX stage. Extends the single-cycle decoder with the full RV32I ALU set (shifts, slt/sltu, xor, lui/auipc), U-type immediates and illegal-opcode reporting; the datapath, hazard unit and PC logic are outside this block.

Parameters:
ALU_CTRL_W, 4, width of the ALU control code; must be >= 4, and bits above [3] are driven 0.
IMM_SRC_W, 3, width of the immediate-select code; must be >= 3, and upper bits are driven 0.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
op_d_i  in  7  opcode of the instruction in ID
funct3_d_i  in  3  funct3 in ID
funct7b5_d_i  in  1  instr[30] in ID
flush_e_i  in  1  insert a bubble into ID/EX at the next edge
stall_e_i  in  1  hold ID/EX, EX/MEM and MEM/WB contents
zero_e_i  in  1  ALU result == 0 (EX)
lt_e_i  in  1  signed rs1 < rs2 (EX)
ltu_e_i  in  1  unsigned rs1 < rs2 (EX)
imm_src_d_o  out  IMM_SRC_W  combinational, ID: 0=I 1=S 2=B 3=J 4=U
illegal_d_o  out  1  combinational, ID: unsupported opcode
alu_ctrl_e_o  out  ALU_CTRL_W  EX ALU operation
alu_src_e_o  out  1  EX ALU B operand: 0=rs2, 1=imm
alu_a_pc_e_o  out  1  EX ALU A operand: 1=PC (auipc)
jalr_e_o  out  1  EX target select: 1=ALU result, 0=PC+imm
pc_src_e_o  out  1  combinational in EX: redirect fetch
result_src_e_o  out  2  EX copy, used by the hazard unit for load-use detection
reg_write_m_o  out  1  MEM register write (forwarding)
mem_write_m_o  out  1  MEM store enable
funct3_m_o  out  3  MEM access size/sign
result_src_w_o  out  2  WB result select: 0=ALU, 1=mem, 2=PC+4
reg_write_w_o  out  1  WB register-file write enable

Behaviour:
- Decode, combinational in ID:
  - R (0110011): reg_write, alu_src 0.
  - I-ALU (0010011): reg_write, imm I.
  - load (0000011): reg_write, imm I, result 1.
  - store (0100011): mem_write, imm S.
  - branch (1100011): branch, imm B, ALU sub.
  - jal (1101111): jump, reg_write, result 2, imm J.
  - jalr (1100111): jump, jalr, reg_write, result 2, imm I, alu_src 1.
  - lui (0110111): imm U, ALU pass-B.
  - auipc (0010111): imm U, alu_a_pc, ALU add.
- ALU codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass-B.
  - funct3 000 gives sub only for R-type with funct7b5=1; I-type 000 is always add.
  - funct3 101 gives sra when funct7b5=1 (R and I), otherwise srl.
  - Loads, stores, jalr and auipc use add.
- Illegal opcode: illegal_d_o=1 and the bundle decodes as a bubble (all write/branch/jump fields 0).
- Bubble: every registered field is 0. This is also the reset value of every registered output.
- Asynchronous reset clears all three stages immediately. imm_src_d_o and illegal_d_o follow their inputs.
- Stage update at each rising edge, with priority stall_e_i > flush_e_i > normal:
  - stall: all three stages hold.
  - flush: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - normal: ID→EX→MEM→WB, one cycle per stage.
- Latency: a decoded instruction appears on the E outputs 1 cycle after it is in ID, on the M outputs after 2 cycles, and on the W outputs after 3 cycles.
- pc_src_e_o = jump_e | (branch_e & cond). funct3_e selects cond:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
  - 010/011: 0
- pc_src_e_o is independent of stall_e_i. The external hazard unit is responsible for asserting flush.

Test Plan:
- Reset: hold rst_ni=0 mid-stream → every E/M/W output reads 0 asynchronously, before any clock edge; after release, a bubble stream keeps them at 0.
- R-type sub (op 0110011, f3 000, f7b5 1) → next cycle alu_ctrl_e_o=1, alu_src_e_o=0; cycle+3 reg_write_w_o=1, result_src_w_o=0. With funct7b5=1 on addi (0010011) → alu_ctrl_e_o=0.
- Shifts: srai (0010011, f3 101, f7b5 1) → alu_ctrl 9; srli (f7b5 0) → 8; lui → 10 with imm_src_d_o=4; auipc → 0 with alu_a_pc_e_o=1.
- Branches in EX:
  - beq with zero=1 → pc_src 1; with zero=0 → 0.
  - bltu with ltu=1 → 1.
  - bge with lt=1 → 0.
  - funct3 010 → 0 regardless of flags.
- Flush/stall:
  - load in ID with flush_e_i=1 → EX bubble: result_src_e_o=0, reg_write_m_o=0 next cycle.
  - stall_e_i=1 for 2 cycles with a store in EX → mem_write_m_o stays at its pre-stall value, and the store reaches MEM 1 cycle after the stall ends.
  - stall and flush asserted together → hold.
- Illegal opcode 0000000 → illegal_d_o=1, and no write/branch/jump fires at E/M/W.
